// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice:
//   - state_e   : arbiter FSM state encoding (IDLE/EXEC/RESP)
//   - FLG_*     : bit positions inside the 4-bit captured flag word
//   - OP_*      : ALU opcodes (ADD .. FACT), same values as opcodes.v
//   - pack_flags: assembles the flag word from the individual ALU flags
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned FLG_ZERO = 0;
    localparam int unsigned FLG_CMP  = 1;
    localparam int unsigned FLG_PODD = 2;
    localparam int unsigned FLG_OVF  = 3;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_MUL  = 6'd2;
    localparam logic [5:0] OP_DIV  = 6'd3;
    localparam logic [5:0] OP_INC  = 6'd4;
    localparam logic [5:0] OP_DEC  = 6'd5;
    localparam logic [5:0] OP_AND  = 6'd6;
    localparam logic [5:0] OP_OR   = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_NOT  = 6'd9;
    localparam logic [5:0] OP_PWR  = 6'd10;
    localparam logic [5:0] OP_FACT = 6'd11;

    function automatic logic [3:0] pack_flags(input logic zero, input logic cmp,
                                              input logic podd, input logic ovf);
        logic [3:0] f;
        f           = '0;
        f[FLG_ZERO] = zero;
        f[FLG_CMP]  = cmp;
        f[FLG_PODD] = podd;
        f[FLG_OVF]  = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every handshake/bus signal of the ALU arbiter:
//   req0_*/req1_* : request channels (valid/ready, func, a, b)
//   rsp0_*/rsp1_* : response channels (valid/ready, result, overf, flags)
//   alu_*         : operand/function drive to and result/flags from the ALU
//   busy, grant_id: status
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus the ALU itself)
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 64
);

    logic             req0_valid;
    logic             req0_ready;
    logic [5:0]       req0_func;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [5:0]       req1_func;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic [31:0]      rsp0_overf;
    logic [3:0]       rsp0_flags;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic [31:0]      rsp1_overf;
    logic [3:0]       rsp1_flags;

    logic [5:0]       alu_function;
    logic [WIDTH-1:0] alu_input1;
    logic [WIDTH-1:0] alu_input2;
    logic [WIDTH-1:0] alu_result;
    logic [31:0]      alu_overf;
    logic             alu_zero;
    logic             alu_compare;
    logic             alu_parity_odd;
    logic             alu_overflow;

    logic             busy;
    logic             grant_id;

    modport slave (
        input  req0_valid, req0_func, req0_a, req0_b,
        input  req1_valid, req1_func, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_overf, rsp0_flags,
        output rsp1_valid, rsp1_result, rsp1_overf, rsp1_flags,
        input  rsp0_ready, rsp1_ready,
        output alu_function, alu_input1, alu_input2,
        input  alu_result, alu_overf, alu_zero, alu_compare, alu_parity_odd, alu_overflow,
        output busy, grant_id
    );

    modport master (
        output req0_valid, req0_func, req0_a, req0_b,
        output req1_valid, req1_func, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_overf, rsp0_flags,
        input  rsp1_valid, rsp1_result, rsp1_overf, rsp1_flags,
        output rsp0_ready, rsp1_ready,
        input  alu_function, alu_input1, alu_input2,
        output alu_result, alu_overf, alu_zero, alu_compare, alu_parity_odd, alu_overflow,
        input  busy, grant_id
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin grant with a priority register.
//   clk, reset  : clock, asynchronous active-high reset
//   en_i        : grants may be issued this cycle
//   req0_i/1_i  : request lines
//   done_i      : current transaction completes at this edge
//   done_id_i   : requester that owned the completing transaction
//   gnt0_o/1_o  : combinational one-hot (or zero) grant
// Priority passes to the other requester only when a transaction completes,
// so an aborted or stalled transaction never rotates it.
// ---------------------------------------------------------------------------
module rr_arbiter2 #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic done_i,
    input  logic done_id_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt0_o = en_i & req0_i & (~req1_i | ~prio_q);
        gnt1_o = en_i & req1_i & (~req0_i |  prio_q);
        prio_d = done_i ? ~done_id_i : prio_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= PRIO_INIT;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. A granted request's
// operands are registered onto the ALU, held for EXEC_CYCLES settle cycles,
// then result/overflow word/flags are captured into the grantee's response
// register and held until that requester takes them.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : alu_arbiter_if.slave (request, response, ALU and status signals)
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned EXEC_CYCLES = 1,
    parameter bit          PRIO_INIT   = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             grant_q;
    logic             busy_q;
    logic [5:0]       fn_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             rsp0_valid_q;
    logic [WIDTH-1:0] rsp0_result_q;
    logic [31:0]      rsp0_overf_q;
    logic [3:0]       rsp0_flags_q;
    logic             rsp1_valid_q;
    logic [WIDTH-1:0] rsp1_result_q;
    logic [31:0]      rsp1_overf_q;
    logic [3:0]       rsp1_flags_q;

    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             rsp_hs;
    logic [5:0]       sel_func;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       flags_in;

    rr_arbiter2 #(
        .PRIO_INIT (PRIO_INIT)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .en_i      (state_q == IDLE),
        .req0_i    (bus.req0_valid),
        .req1_i    (bus.req1_valid),
        .done_i    (rsp_hs),
        .done_id_i (grant_q),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1)
    );

    always_comb begin
        accept   = gnt0 | gnt1;
        sel_func = gnt1 ? bus.req1_func : bus.req0_func;
        sel_a    = gnt1 ? bus.req1_a    : bus.req0_a;
        sel_b    = gnt1 ? bus.req1_b    : bus.req0_b;
        // Only the grantee's response channel can complete the transaction;
        // the other requester's ready is ignored.
        rsp_hs   = (state_q == RESP) &&
                   (grant_q ? (rsp1_valid_q & bus.rsp1_ready)
                            : (rsp0_valid_q & bus.rsp0_ready));
        flags_in = pack_flags(bus.alu_zero, bus.alu_compare,
                              bus.alu_parity_odd, bus.alu_overflow);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            grant_q       <= PRIO_INIT;
            busy_q        <= 1'b0;
            fn_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_overf_q  <= '0;
            rsp0_flags_q  <= '0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_overf_q  <= '0;
            rsp1_flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        fn_q    <= sel_func;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        grant_q <= gnt1;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        if (grant_q) begin
                            rsp1_valid_q  <= 1'b1;
                            rsp1_result_q <= bus.alu_result;
                            rsp1_overf_q  <= bus.alu_overf;
                            rsp1_flags_q  <= flags_in;
                        end else begin
                            rsp0_valid_q  <= 1'b1;
                            rsp0_result_q <= bus.alu_result;
                            rsp0_overf_q  <= bus.alu_overf;
                            rsp0_flags_q  <= flags_in;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready   = gnt0;
    assign bus.req1_ready   = gnt1;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp0_result  = rsp0_result_q;
    assign bus.rsp0_overf   = rsp0_overf_q;
    assign bus.rsp0_flags   = rsp0_flags_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign bus.rsp1_result  = rsp1_result_q;
    assign bus.rsp1_overf   = rsp1_overf_q;
    assign bus.rsp1_flags   = rsp1_flags_q;
    assign bus.alu_function = fn_q;
    assign bus.alu_input1   = a_q;
    assign bus.alu_input2   = b_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = grant_q;

endmodule
